piece_queue: RTL

- Downstream consumer of the free-running random word produced by the clock-sampling random generator.
- Takes a 32-bit entropy word as a one-shot seed and runs a 32-bit Galois LFSR from it.
- Produces tetromino IDs 0..6 using NES-style previous-piece reroll, buffered in a DEPTH-entry preview FIFO.
- Exposed to the Nios software as an Avalon-MM slave with peek, pop, status and reseed registers.

---
 rtl/piece_queue.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/piece_queue.sv
// -----------------------------------------------------------------------------
// piece_queue
//   Tetromino preview queue. A 32-bit entropy word seeds a Galois LFSR; each
//   step yields a 3-bit candidate that is turned into a piece ID 0..6 and
//   pushed into a DEPTH-entry FIFO. Software peeks, pops, reads status and
//   reseeds through a small Avalon-MM slave with zero read latency.
//
//   Optional build macro: PIECE_QUEUE_REROLL_EN
//     defined   : NES-style selection (a candidate equal to the previous piece
//                 is rerolled once, and the reroll is (cand + prev) mod 7).
//     undefined : only candidate 7 is rejected; a reject simply rolls again.
//
// Ports
//   CLK            system clock
//   RESET          asynchronous active-high reset
//   SEED[31:0]     entropy word for hardware reseed
//   SEED_LOAD      one-cycle hardware reseed strobe (wins over a bus reseed)
//   AVL_CS/READ/WRITE, AVL_ADDR[1:0], AVL_WRITEDATA[31:0]  slave request
//   AVL_READDATA[31:0]   0: peek, 1: pop, 2: status, 3: LFSR (combinational)
// -----------------------------------------------------------------------------
module piece_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] SEED,
    input  logic        SEED_LOAD,
    input  logic        AVL_CS,
    input  logic        AVL_READ,
    input  logic        AVL_WRITE,
    input  logic [1:0]  AVL_ADDR,
    input  logic [31:0] AVL_WRITEDATA,
    output logic [31:0] AVL_READDATA
);

    localparam logic [1:0] ST_UNSEEDED = 2'd0;
    localparam logic [1:0] ST_ROLL1    = 2'd1;
    localparam logic [1:0] ST_ROLL2    = 2'd2;
    localparam logic [1:0] ST_FULL     = 2'd3;

    localparam logic [3:0] DEPTH_C    = 4'(DEPTH);
    localparam logic [3:0] LAST_C     = 4'(DEPTH - 1);
    localparam logic [2:0] PIECE_NONE = 3'd7;

    logic [1:0]  r_state;
    logic [31:0] r_lfsr;
    logic [2:0]  r_mem [0:15];
    logic [3:0]  r_rd_ptr;
    logic [3:0]  r_wr_ptr;
    logic [3:0]  r_count;
    logic        r_underflow;

    logic [31:0] w_next;
    logic [2:0]  w_cand;
    logic        w_accept1;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic [2:0]  w_push_val;
    logic        w_step;
    logic [1:0]  w_state_nxt;
    logic        w_pop_req;
    logic        w_pop;
    logic        w_uf_set;
    logic        w_uf_clr;
    logic        w_reseed;
    logic [31:0] w_seed_raw;
    logic [31:0] w_seed_val;
    logic [2:0]  w_head;

`ifdef PIECE_QUEUE_REROLL_EN
    logic [2:0]  r_prev;
    logic [3:0]  w_sum;
    logic [2:0]  w_mod7;
`endif

    // Wrap a FIFO pointer at the configured depth rather than at 16.
    function automatic logic [3:0] ptr_inc(input logic [3:0] ptr);
        logic [3:0] res;
        if (ptr == LAST_C) begin
            res = 4'd0;
        end else begin
            res = ptr + 4'd1;
        end
        return res;
    endfunction

    // LFSR next value, candidate, FIFO flags and bus request decode.
    always_comb begin
        w_next     = r_lfsr[0] ? ({1'b0, r_lfsr[31:1]} ^ LFSR_POLY) : {1'b0, r_lfsr[31:1]};
        w_cand     = w_next[2:0];
        w_full     = (r_count == DEPTH_C);
        w_empty    = (r_count == 4'd0);
        w_head     = w_empty ? PIECE_NONE : r_mem[r_rd_ptr];
        w_pop_req  = AVL_CS & AVL_READ & (AVL_ADDR == 2'd1);
        w_pop      = w_pop_req & ~w_empty;
        w_uf_set   = w_pop_req & w_empty;
        w_uf_clr   = AVL_CS & AVL_WRITE & (AVL_ADDR == 2'd2);
        w_reseed   = SEED_LOAD | (AVL_CS & AVL_WRITE & (AVL_ADDR == 2'd3));
        w_seed_raw = SEED_LOAD ? SEED : AVL_WRITEDATA;
        // An all-zero seed would lock the LFSR, so it is forced to 1.
        w_seed_val = (w_seed_raw == 32'd0) ? 32'd1 : w_seed_raw;
    end

`ifdef PIECE_QUEUE_REROLL_EN
    // Reroll value: 4-bit sum of candidate and previous piece, reduced mod 7.
    always_comb begin
        w_sum = {1'b0, w_cand} + {1'b0, r_prev};
        if (w_sum >= 4'd14) begin
            w_mod7 = 3'(w_sum - 4'd14);
        end else if (w_sum >= 4'd7) begin
            w_mod7 = 3'(w_sum - 4'd7);
        end else begin
            w_mod7 = w_sum[2:0];
        end
        w_accept1 = (w_cand != PIECE_NONE) && (w_cand != r_prev);
    end
`else
    // First-roll acceptance: only the out-of-range candidate is rejected.
    always_comb begin
        w_accept1 = (w_cand != PIECE_NONE);
    end
`endif

    // Generator FSM: decides push, LFSR advance and next state. A push that
    // would overflow parks the FSM in FULL with the LFSR held.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_val  = w_cand;
        w_step      = 1'b0;
        case (r_state)
            ST_ROLL1: begin
                if (!w_accept1) begin
                    w_step      = 1'b1;
                    w_state_nxt = ST_ROLL2;
                end else if (w_full) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_push = 1'b1;
                    w_step = 1'b1;
                end
            end
            ST_ROLL2: begin
`ifdef PIECE_QUEUE_REROLL_EN
                w_push_val = w_mod7;
                if (w_full) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_push      = 1'b1;
                    w_step      = 1'b1;
                    w_state_nxt = ST_ROLL1;
                end
`else
                if (w_cand == PIECE_NONE) begin
                    w_step = 1'b1;
                end else if (w_full) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_push      = 1'b1;
                    w_step      = 1'b1;
                    w_state_nxt = ST_ROLL1;
                end
`endif
            end
            ST_FULL: begin
                if (w_full) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_ROLL1;
                end
            end
            ST_UNSEEDED: begin
                w_state_nxt = ST_UNSEEDED;
            end
            default: begin
                w_state_nxt = ST_UNSEEDED;
            end
        endcase
    end

    // FSM state, LFSR and previous-piece registers; reseed overrides all.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_UNSEEDED;
            r_lfsr  <= 32'd1;
`ifdef PIECE_QUEUE_REROLL_EN
            r_prev  <= PIECE_NONE;
`endif
        end else if (w_reseed) begin
            r_state <= ST_ROLL1;
            r_lfsr  <= w_seed_val;
`ifdef PIECE_QUEUE_REROLL_EN
            r_prev  <= PIECE_NONE;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_step) begin
                r_lfsr <= w_next;
            end
`ifdef PIECE_QUEUE_REROLL_EN
            if (w_push) begin
                r_prev <= w_push_val;
            end
`endif
        end
    end

    // Preview FIFO storage, pointers and occupancy; reseed flushes it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_ptr <= 4'd0;
            r_wr_ptr <= 4'd0;
            r_count  <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 3'd0;
            end
        end else if (w_reseed) begin
            r_rd_ptr <= 4'd0;
            r_wr_ptr <= 4'd0;
            r_count  <= 4'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_val;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky underflow flag: set by a pop of an empty queue, cleared by a
    // status write or any reseed.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_underflow <= 1'b0;
        end else if (w_reseed) begin
            r_underflow <= 1'b0;
        end else if (w_uf_set) begin
            r_underflow <= 1'b1;
        end else if (w_uf_clr) begin
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= r_underflow;
        end
    end

    // Zero-latency read mux.
    always_comb begin
        case (AVL_ADDR)
            2'd0:    AVL_READDATA = {29'd0, w_head};
            2'd1:    AVL_READDATA = {29'd0, w_head};
            2'd2:    AVL_READDATA = {23'd0, r_underflow, r_count, 3'd0, (r_state != ST_UNSEEDED)};
            2'd3:    AVL_READDATA = r_lfsr;
            default: AVL_READDATA = 32'd0;
        endcase
    end

endmodule
